// File: rtl/mask_centroid.sv
// Per-frame mask statistics with a serial restoring divider for the centroid.
// Timing and mask pass through with one enabled cycle of latency.
module mask_centroid #(
   parameter int unsigned H_SIZE     = 64,
   parameter int unsigned V_SIZE     = 64,
   parameter int unsigned MIN_PIXELS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        mask,
   input  logic        in_de,
   input  logic        in_vsync,
   input  logic        in_hsync,
   output logic        out_mask,
   output logic        out_de,
   output logic        out_vsync,
   output logic        out_hsync,
   output logic [9:0]  x_center,
   output logic [9:0]  y_center,
   output logic [9:0]  x_min,
   output logic [9:0]  x_max,
   output logic [9:0]  y_min,
   output logic [9:0]  y_max,
   output logic [19:0] pixel_count,
   output logic        detected,
   output logic        result_valid,
   output logic        overrun
);

   localparam logic [9:0]  X_LAST  = 10'(H_SIZE - 1);
   localparam logic [9:0]  Y_LAST  = 10'(V_SIZE - 1);
   localparam logic [20:0] MIN_CNT = 21'(MIN_PIXELS);

   typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, DONE} state_t;

   state_t      state_q, state_d;
   logic        vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [19:0] cnt_q, cnt_d;
   logic [29:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
   logic [19:0] snap_cnt_q, snap_cnt_d;
   logic [29:0] snap_sx_q, snap_sx_d, snap_sy_q, snap_sy_d;
   logic [9:0]  snap_xmin_q, snap_xmin_d, snap_xmax_q, snap_xmax_d;
   logic [9:0]  snap_ymin_q, snap_ymin_d, snap_ymax_q, snap_ymax_d;
   logic [19:0] rem_q, rem_d;
   logic [29:0] dq_q, dq_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [9:0]  qx_q, qx_d;
   logic        det_q, det_d;
   logic        out_mask_q, out_mask_d, out_de_q, out_de_d;
   logic        out_vsync_q, out_vsync_d, out_hsync_q, out_hsync_d;
   logic [9:0]  x_center_q, x_center_d, y_center_q, y_center_d;
   logic [9:0]  x_min_q, x_min_d, x_max_q, x_max_d, y_min_q, y_min_d, y_max_q, y_max_d;
   logic [19:0] pixel_count_q, pixel_count_d;
   logic        detected_q, detected_d, result_valid_q, result_valid_d;
   logic        overrun_q, overrun_d;

   logic        vs_rise, de_fall, pix;
   logic [9:0]  cur_x, cur_y;
   logic [19:0] cnt_b;
   logic [29:0] sum_x_b, sum_y_b;
   logic [9:0]  xmin_b, xmax_b, ymin_b, ymax_b;
   logic [20:0] rem_sh;
   logic        div_ge;
   logic [19:0] rem_nx;
   logic [29:0] dq_nx;

   // A pixel on the vsync-rise cycle already belongs to the new frame, at (0,0).
   assign vs_rise = in_vsync & ~vs_prev_q;
   assign de_fall = de_prev_q & ~in_de;
   assign pix     = in_de & mask;
   assign cur_x   = vs_rise ? '0 : x_q;
   assign cur_y   = vs_rise ? '0 : y_q;

   assign rem_sh = {rem_q, dq_q[29]};
   assign div_ge = rem_sh >= {1'b0, snap_cnt_q};
   assign rem_nx = div_ge ? 20'(rem_sh - {1'b0, snap_cnt_q}) : rem_sh[19:0];
   assign dq_nx  = {dq_q[28:0], div_ge};

   always_comb begin
      vs_prev_d   = in_vsync;
      de_prev_d   = in_de;
      out_mask_d  = mask;
      out_de_d    = in_de;
      out_vsync_d = in_vsync;
      out_hsync_d = in_hsync;

      x_d = cur_x;
      y_d = cur_y;
      if (in_de) begin
         x_d = (cur_x >= X_LAST) ? X_LAST : cur_x + 10'd1;
      end else if (de_fall && !vs_rise) begin
         x_d = '0;
         y_d = (y_q >= Y_LAST) ? Y_LAST : y_q + 10'd1;
      end

      cnt_b   = vs_rise ? '0 : cnt_q;
      sum_x_b = vs_rise ? '0 : sum_x_q;
      sum_y_b = vs_rise ? '0 : sum_y_q;
      xmin_b  = vs_rise ? '1 : xmin_q;
      xmax_b  = vs_rise ? '0 : xmax_q;
      ymin_b  = vs_rise ? '1 : ymin_q;
      ymax_b  = vs_rise ? '0 : ymax_q;
      cnt_d   = cnt_b;
      sum_x_d = sum_x_b;
      sum_y_d = sum_y_b;
      xmin_d  = xmin_b;
      xmax_d  = xmax_b;
      ymin_d  = ymin_b;
      ymax_d  = ymax_b;
      if (pix) begin
         cnt_d   = cnt_b + 20'd1;
         sum_x_d = sum_x_b + 30'(cur_x);
         sum_y_d = sum_y_b + 30'(cur_y);
         xmin_d  = (cur_x < xmin_b) ? cur_x : xmin_b;
         xmax_d  = (cur_x > xmax_b) ? cur_x : xmax_b;
         ymin_d  = (cur_y < ymin_b) ? cur_y : ymin_b;
         ymax_d  = (cur_y > ymax_b) ? cur_y : ymax_b;
      end

      snap_cnt_d  = snap_cnt_q;
      snap_sx_d   = snap_sx_q;
      snap_sy_d   = snap_sy_q;
      snap_xmin_d = snap_xmin_q;
      snap_xmax_d = snap_xmax_q;
      snap_ymin_d = snap_ymin_q;
      snap_ymax_d = snap_ymax_q;
      if (vs_rise && state_q == IDLE) begin
         snap_cnt_d  = cnt_q;
         snap_sx_d   = sum_x_q;
         snap_sy_d   = sum_y_q;
         snap_xmin_d = xmin_q;
         snap_xmax_d = xmax_q;
         snap_ymin_d = ymin_q;
         snap_ymax_d = ymax_q;
      end
      overrun_d = vs_rise && (state_q != IDLE);

      state_d        = state_q;
      rem_d          = rem_q;
      dq_d           = dq_q;
      bit_cnt_d      = bit_cnt_q;
      qx_d           = qx_q;
      det_d          = det_q;
      x_center_d     = x_center_q;
      y_center_d     = y_center_q;
      x_min_d        = x_min_q;
      x_max_d        = x_max_q;
      y_min_d        = y_min_q;
      y_max_d        = y_max_q;
      pixel_count_d  = pixel_count_q;
      detected_d     = detected_q;
      result_valid_d = 1'b0;

      case (state_q)
         IDLE: if (vs_rise) state_d = CHECK;
         CHECK: begin
            // An empty frame never reaches the divider, even with MIN_PIXELS=0.
            if ({1'b0, snap_cnt_q} >= MIN_CNT && snap_cnt_q != '0) begin
               det_d     = 1'b1;
               dq_d      = snap_sx_q;
               rem_d     = '0;
               bit_cnt_d = '0;
               state_d   = DIV_X;
            end else begin
               det_d   = 1'b0;
               state_d = DONE;
            end
         end
         DIV_X: begin
            rem_d     = rem_nx;
            dq_d      = dq_nx;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd29) begin
               qx_d      = dq_nx[9:0];
               dq_d      = snap_sy_q;
               rem_d     = '0;
               bit_cnt_d = '0;
               state_d   = DIV_Y;
            end
         end
         DIV_Y: begin
            rem_d     = rem_nx;
            dq_d      = dq_nx;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd29) state_d = DONE;
         end
         DONE: begin
            result_valid_d = 1'b1;
            pixel_count_d  = snap_cnt_q;
            detected_d     = det_q;
            if (det_q) begin
               x_center_d = qx_q;
               y_center_d = dq_q[9:0];
               x_min_d    = snap_xmin_q;
               x_max_d    = snap_xmax_q;
               y_min_d    = snap_ymin_q;
               y_max_d    = snap_ymax_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         vs_prev_q <= 1'b0;  de_prev_q <= 1'b0;
         x_q <= '0;  y_q <= '0;
         cnt_q <= '0;  sum_x_q <= '0;  sum_y_q <= '0;
         xmin_q <= '1;  xmax_q <= '0;  ymin_q <= '1;  ymax_q <= '0;
         snap_cnt_q <= '0;  snap_sx_q <= '0;  snap_sy_q <= '0;
         snap_xmin_q <= '0;  snap_xmax_q <= '0;  snap_ymin_q <= '0;  snap_ymax_q <= '0;
         rem_q <= '0;  dq_q <= '0;  bit_cnt_q <= '0;  qx_q <= '0;  det_q <= 1'b0;
         out_mask_q <= 1'b0;  out_de_q <= 1'b0;  out_vsync_q <= 1'b0;  out_hsync_q <= 1'b0;
         x_center_q <= '0;  y_center_q <= '0;
         x_min_q <= '0;  x_max_q <= '0;  y_min_q <= '0;  y_max_q <= '0;
         pixel_count_q <= '0;  detected_q <= 1'b0;
         result_valid_q <= 1'b0;  overrun_q <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         vs_prev_q <= vs_prev_d;  de_prev_q <= de_prev_d;
         x_q <= x_d;  y_q <= y_d;
         cnt_q <= cnt_d;  sum_x_q <= sum_x_d;  sum_y_q <= sum_y_d;
         xmin_q <= xmin_d;  xmax_q <= xmax_d;  ymin_q <= ymin_d;  ymax_q <= ymax_d;
         snap_cnt_q <= snap_cnt_d;  snap_sx_q <= snap_sx_d;  snap_sy_q <= snap_sy_d;
         snap_xmin_q <= snap_xmin_d;  snap_xmax_q <= snap_xmax_d;
         snap_ymin_q <= snap_ymin_d;  snap_ymax_q <= snap_ymax_d;
         rem_q <= rem_d;  dq_q <= dq_d;  bit_cnt_q <= bit_cnt_d;  qx_q <= qx_d;  det_q <= det_d;
         out_mask_q <= out_mask_d;  out_de_q <= out_de_d;
         out_vsync_q <= out_vsync_d;  out_hsync_q <= out_hsync_d;
         x_center_q <= x_center_d;  y_center_q <= y_center_d;
         x_min_q <= x_min_d;  x_max_q <= x_max_d;  y_min_q <= y_min_d;  y_max_q <= y_max_d;
         pixel_count_q <= pixel_count_d;  detected_q <= detected_d;
         result_valid_q <= result_valid_d;  overrun_q <= overrun_d;
      end
   end

   assign out_mask     = out_mask_q;
   assign out_de       = out_de_q;
   assign out_vsync    = out_vsync_q;
   assign out_hsync    = out_hsync_q;
   assign x_center     = x_center_q;
   assign y_center     = y_center_q;
   assign x_min        = x_min_q;
   assign x_max        = x_max_q;
   assign y_min        = y_min_q;
   assign y_max        = y_max_q;
   assign pixel_count  = pixel_count_q;
   assign detected     = detected_q;
   assign result_valid = result_valid_q;
   assign overrun      = overrun_q;

endmodule
